// File: rtl/note_synth_pkg.sv
// note_synth_pkg: shared widths, types and the triangle shaping helper for note_synth
package note_synth_pkg;
  localparam int FREQ_W = 12;
  localparam int VOL_W = 8;
  localparam int WAVE_W = 16;
  typedef logic [FREQ_W-1:0] freq_t;
  typedef logic [VOL_W-1:0] vol_t;
  typedef logic [WAVE_W-1:0] wave_t;
  function automatic wave_t tri_wave(input logic [WAVE_W:0] p);
    return p[WAVE_W] ? ~p[WAVE_W-1:0] : p[WAVE_W-1:0];
  endfunction
endpackage

// File: rtl/note_synth_input_stabilizer.sv
// input_stabilizer: 2-flop sync plus stability filter producing a stable word and a load strobe
module input_stabilizer #(
  parameter int W = 20,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  input  logic [W-1:0] cur_i,
  output logic [W-1:0] q_o,
  output logic         update_o
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [W-1:0] s1_q, s2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (s2_q != prev_q) ? '0 : (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
    update_o = (cnt_d == CW'(STABLE_CYCLES)) && (s2_q != cur_i);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
      cnt_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      prev_q <= s2_q;
      cnt_q <= cnt_d;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/note_synth.sv
// note_synth: filtered freq/volume, phase-accumulator note and gated PWM carrier; NOTE_SYNTH_TRIANGLE_EN selects triangle wave
module note_synth
  import note_synth_pkg::*;
#(
  parameter int CLK_HZ = 40_000_000,
  parameter int ACC_W = 36,
  parameter int PHASE_K = int'(((64'd1 << ACC_W) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ)),
  parameter int CARRIER_DIV = CLK_HZ / 125_000,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic [VOL_W-1:0]  volume_in,
  output logic [FREQ_W-1:0] freq,
  output logic [VOL_W-1:0]  volume,
  output logic              note_on,
  output logic [WAVE_W-1:0] wave,
  output logic              pwm_out
);
  localparam int CNT_W = $clog2(CARRIER_DIV);
  freq_t freq_q;
  vol_t volume_q;
  wave_t wave_q, wave_d;
  logic [ACC_W-1:0] phase_q, phase_d, inc;
  logic [CNT_W-1:0] ccnt_q, ccnt_d, thr_q, thr_d;
  logic [VOL_W+CNT_W-1:0] prod;
  logic [FREQ_W+VOL_W-1:0] word;
  logic update, pwm_q, pwm_d;
  input_stabilizer #(.W(FREQ_W + VOL_W), .STABLE_CYCLES(STABLE_CYCLES)) u_stab (
    .clk(clk),
    .reset(reset),
    .d_i({freq_in, volume_in}),
    .cur_i({freq_q, volume_q}),
    .q_o(word),
    .update_o(update)
  );
  assign note_on = (freq_q != '0) && (volume_q != '0);
  always_comb begin
    inc = ACC_W'(freq_q) * ACC_W'(PHASE_K);
    phase_d = (freq_q == '0) ? '0 : phase_q + inc;
    ccnt_d = (ccnt_q == CNT_W'(CARRIER_DIV - 1)) ? '0 : ccnt_q + 1'b1;
    prod = (VOL_W+CNT_W)'(volume_q) * (VOL_W+CNT_W)'(CARRIER_DIV);
    thr_d = (ccnt_q == '0) ? CNT_W'(prod >> VOL_W) : thr_q;
    pwm_d = note_on & phase_q[ACC_W-1] & (ccnt_q < thr_d);
`ifdef NOTE_SYNTH_TRIANGLE_EN
    wave_d = (freq_q == '0) ? '0 : tri_wave(phase_q[ACC_W-1 -: WAVE_W+1]);
`else
    wave_d = (freq_q == '0 || !phase_q[ACC_W-1]) ? '0 : '1;
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      freq_q <= '0;
      volume_q <= '0;
      phase_q <= '0;
      wave_q <= '0;
      ccnt_q <= '0;
      thr_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      {freq_q, volume_q} <= update ? word : {freq_q, volume_q};
      phase_q <= phase_d;
      wave_q <= wave_d;
      ccnt_q <= ccnt_d;
      thr_q <= thr_d;
      pwm_q <= pwm_d;
    end
  end
  assign freq = freq_q;
  assign volume = volume_q;
  assign wave = wave_q;
  assign pwm_out = pwm_q;
endmodule
